// File: rtl/lfsr_gen.sv
// Runtime-configurable Fibonacci/Galois LFSR with loadable seed and taps,
// all-zero lockup recovery and period measurement back to the loaded seed.
module lfsr_gen #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_TAP  = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] tap,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] dout,
  output logic             bit_out,
  output logic             lockup,
  output logic             lockup_seen,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  typedef enum logic {
    FIBONACCI = 1'b0,
    GALOIS    = 1'b1
  } mode_e;

  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_tap;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_period_valid;
  logic             r_lockup_seen;

  logic [WIDTH-1:0] w_fib;
  logic [WIDTH-1:0] w_gal;
  logic [WIDTH-1:0] w_next;
  logic             w_lockup;
  logic             w_cnt_full;

  assign w_fib      = {r_lfsr[WIDTH-2:0], ^(r_lfsr & r_tap)};
  assign w_gal      = (r_lfsr << 1) ^ (r_lfsr[WIDTH-1] ? r_tap : '0);
  assign w_lockup   = (r_lfsr == '0);
  assign w_cnt_full = &r_cnt;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_next = w_fib;
    if (w_lockup) begin
      w_next = WIDTH'(1);
    end else if (r_mode == GALOIS) begin
      w_next = w_gal;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lfsr         <= RESET_SEED;
      r_seed         <= RESET_SEED;
      r_tap          <= RESET_TAP;
      r_mode         <= FIBONACCI;
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_lockup_seen  <= 1'b0;
    end else if (load) begin
      r_lfsr         <= seed;
      r_seed         <= seed;
      r_tap          <= tap;
      r_mode         <= mode_e'(mode);
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_lockup_seen  <= 1'b0;
    end else if (en) begin
      r_lfsr <= w_next;
      if (w_lockup) begin
        r_lockup_seen <= 1'b1;
      end
      // Recovery counts as a step; a saturated count leaves the flag low.
      if (!r_period_valid) begin
        if (w_next == r_seed) begin
          r_period       <= r_cnt + WIDTH'(1);
          r_period_valid <= 1'b1;
        end else if (!w_cnt_full) begin
          r_cnt <= r_cnt + WIDTH'(1);
        end
      end
    end
  end

  assign dout         = r_lfsr;
  assign bit_out      = r_lfsr[WIDTH-1];
  assign lockup       = w_lockup;
  assign lockup_seen  = r_lockup_seen;
  assign period       = r_period;
  assign period_valid = r_period_valid;

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised, runtime-configurable linear-feedback shift register with loadable seed, taps and mode. Supports Fibonacci and Galois feedback, steps only when enabled, detects and recovers from all-zero lockup, and measures the sequence period back to the loaded seed. It is the general-width successor to the team's fixed 8-bit LFSR and serves as a pattern and scrambler source for the test and stimulus blocks.

## Interface
- `WIDTH`, 8: register width, ≥ 2.
- `RESET_SEED`, 1: state value while reset is asserted (WIDTH bits).
- `RESET_TAP`, 8'hB8 zero-extended: tap mask while reset is asserted.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `load`  in  1  load strobe; captures `seed`, `tap` and `mode`.
- `seed`  in  WIDTH  seed value, sampled on `load`.
- `tap`  in  WIDTH  tap mask, sampled on `load`.
- `mode`  in  1  feedback type, sampled on `load`: 0 Fibonacci, 1 Galois.
- `en`  in  1  step enable.
- `dout`  out  WIDTH  current state.
- `bit_out`  out  1  serial output, equal to `dout[WIDTH-1]`.
- `lockup`  out  1  combinational flag, high when state == 0.
- `lockup_seen`  out  1  sticky; set by a lockup recovery, cleared by `load`.
- `period`  out  WIDTH  measured period; valid only when `period_valid` is high.
- `period_valid`  out  1  period measurement complete.

## Operation
**Registers.** `lfsr`, `seed_r`, `tap_r`, `mode_r`, `cnt` (WIDTH bits), `period`, `period_valid`, `lockup_seen`.

**Reset.** While `resetn` is low:
- `lfsr` = `seed_r` = RESET_SEED; `tap_r` = RESET_TAP; `mode_r` = 0.
- `cnt`, `period`, `period_valid`, `lockup_seen` = 0.
- Therefore `dout` = RESET_SEED, and `lockup` = (RESET_SEED == 0).

**Priority each cycle:** load > lockup recovery > step > hold.

**Load (`load` = 1).**
- `lfsr` ← `seed`, `seed_r` ← `seed`, `tap_r` ← `tap`, `mode_r` ← `mode`.
- `cnt`, `period`, `period_valid`, `lockup_seen` ← 0.
- `en` is ignored in that cycle.

**Lockup recovery (`en` = 1, `lfsr` == 0).**
- `lfsr` ← 1, `lockup_seen` ← 1.
- Counts as a step for `cnt`.

**Step (`en` = 1, `lfsr` ≠ 0).** `nxt` depends on `mode_r`:
- Fibonacci: `nxt` = {`lfsr[WIDTH-2:0]`, ^(`lfsr` & `tap_r`)}.
- Galois: `nxt` = (`lfsr` << 1) ^ (`lfsr[WIDTH-1]` ? `tap_r` : 0).
- `lfsr` ← `nxt`.

**Hold (`en` = 0, no load).** All registers hold.

**Period measurement.** Applies on every step and every recovery while `period_valid` = 0:
- If `nxt` == `seed_r`: `period` ← `cnt` + 1, `period_valid` ← 1.
- Else, if `cnt` ≠ all-ones: `cnt` ← `cnt` + 1.
- Else: `cnt` saturates and `period_valid` stays 0, for singular taps or a zero seed.

Once `period_valid` = 1, `cnt` and `period` freeze until the next `load`. The LFSR keeps stepping.

**Tap and mode changes.** They take effect only via `load`; `tap` and `mode` are don't-care otherwise.

## Timing
- One step per enabled cycle; `dout` reflects a step one cycle after the `en` edge.
- Load-to-output latency is 1 cycle; `dout` == `seed` in the cycle after `load`.
- `period_valid` rises in the same cycle that `dout` returns to `seed_r`.
- `lockup` and `bit_out` are combinational from registered state, so they are glitch-free relative to `clk`.
- Reset asserted mid-sequence clears all state immediately, without waiting for `clk`. The first step after deassertion uses RESET_SEED and RESET_TAP in Fibonacci mode.
- `load` and `en` high together: load only, and `cnt` stays 0.

## Test plan
1. **Fibonacci, maximal taps.** WIDTH = 8; `load` with `seed` = 0x01, `tap` = 0xB8, `mode` = 0; `en` held high.
   - `dout` runs 0x01, 0x02, 0x04, 0x08, 0x11, …
   - `period_valid` = 1 with `period` = 255 after 255 steps.
2. **Galois, maximal taps.** `seed` = 0x01, `tap` = 0x1D, `mode` = 1.
   - After 7 steps `dout` = 0x80; the 8th step gives 0x1D.
   - `period` = 255.
3. **Non-maximal taps.** `tap` = 0x80, Fibonacci, `seed` = 0x01.
   - `dout` rotates left (0x01, 0x02, …, 0x80, 0x01).
   - `period` = 8, `period_valid` = 1 at the 8th step.
4. **Lockup.** `load` `seed` = 0x00.
   - Next cycle `lockup` = 1.
   - The first `en` step gives `dout` = 0x01, `lockup` = 0, `lockup_seen` = 1.
   - `period_valid` stays 0 and `cnt` saturates at 0xFF.
5. **Enable gating and simultaneous events.**
   - Toggle `en` 1/0: `dout` advances only on `en` = 1 cycles.
   - Assert `load` and `en` together with `seed` = 0x5A: `dout` = 0x5A next cycle, with no step applied.
6. **Asynchronous reset mid-run.** Drop `resetn` between clock edges during a sequence.
   - `dout` = RESET_SEED and `period_valid` = 0 immediately.
   - After release, the first step follows RESET_TAP in Fibonacci mode.
